// File: rtl/bootstrap_pkg.sv
// Shared types and sizing helpers for the bootstrap reset sequencer.
package bootstrap_pkg;

    typedef enum logic [2:0] {
        DELAY,
        WAIT_RDY,
        DONE,
        ERROR,
        HOLD_ALL
    } seq_state_e;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bootstrap_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module bootstrap_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic HCLK,
    input  logic async_resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge HCLK or negedge async_resetn) begin
        if (!async_resetn) chain <= '0;
        else               chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/bootstrap_reset_sequencer.sv
// Releases per-domain resets in order, each after a settle delay and only once
// the previous domain reports ready; flags the first domain that never does.
module bootstrap_reset_sequencer
    import bootstrap_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                  HCLK,
    input  logic                  async_resetn,
    input  logic [NUM_STAGES-1:0] STAGE_READY,
    input  logic                  SOFT_SEQ_REQ,
    output logic [NUM_STAGES-1:0] STAGE_RESETN,
    output logic                  BOOT_DONE,
    output logic                  TIMEOUT_ERR,
    output logic [2:0]            FAIL_STAGE
);

    localparam int             CW       = $clog2(max(STAGE_DELAY, ACK_TIMEOUT)) + 1;
    localparam logic [CW-1:0]  DLY_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [2:0]     LAST_IDX = 3'(NUM_STAGES - 1);

    logic [NUM_STAGES-1:0] rdy_sync;
    logic [NUM_STAGES-1:0] sel;
    logic                  rdy_cur;

    seq_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_STAGES-1:0] rstn_q, rstn_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [2:0]            fail_q, fail_d;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_sync
        bootstrap_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .HCLK         (HCLK),
            .async_resetn (async_resetn),
            .d            (STAGE_READY[g]),
            .q            (rdy_sync[g])
        );
    end

    // One-hot of the current stage; ready bits of other stages are ignored.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (idx_q == 3'(i)) sel[i] = 1'b1;
    end

    assign rdy_cur = |(rdy_sync & sel);

    always_ff @(posedge HCLK or negedge async_resetn) begin
        if (!async_resetn) begin
            state_q <= DELAY;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        err_d   = err_q;
        fail_d  = fail_q;
        if (SOFT_SEQ_REQ) begin
            state_d = HOLD_ALL;
            cnt_d   = '0;
            idx_d   = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            fail_d  = '0;
        end else begin
            case (state_q)
                DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        rstn_d  = rstn_q | sel;
                        cnt_d   = '0;
                        state_d = WAIT_RDY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_RDY: begin
                    // Ready is checked first so it wins on the timeout cycle.
                    if (rdy_cur) begin
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            cnt_d   = '0;
                            state_d = DELAY;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        fail_d  = idx_q;
                        state_d = ERROR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD_ALL: begin
                    if (cnt_q == DLY_LAST) begin
                        cnt_d   = '0;
                        state_d = DELAY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE, ERROR: ;
                default: state_d = DELAY;
            endcase
        end
    end

    assign STAGE_RESETN = rstn_q;
    assign BOOT_DONE    = done_q;
    assign TIMEOUT_ERR  = err_q;
    assign FAIL_STAGE   = fail_q;

endmodule
